// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch sequencer for a combinational-read instruction ROM.
// Owns the program counter, presents it to the ROM every cycle, and captures
// the returned word together with its PC into a 2-entry FIFO.  Decode drains
// the FIFO through a valid/ready handshake.  Redirects flush the FIFO and
// restart fetch.  Misaligned or out-of-range fetch attempts park the
// sequencer in a sticky fault state until the next redirect.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   imem_addr    out  byte address to the ROM (always equals the PC)
//   imem_data    in   ROM word for imem_addr, same cycle
//   instr_valid  out  FIFO head holds an instruction
//   instr_ready  in   decode accepts the head this cycle
//   instr        out  head instruction word (0 when empty)
//   instr_pc     out  PC of the head instruction (0 when empty)
//   redirect     in   flush and restart fetch at redirect_pc
//   redirect_pc  in   new PC
//   halt         in   level; suppresses new fetches while high
//   fault        out  sticky fetch fault
//   fault_pc     out  PC that caused the fault
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              LOGWORDS = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              ILEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int DEPTH = 2;

    state_t          state_reg,    state_next;
    logic [XLEN-1:0] pc_reg,       pc_next;
    logic [XLEN-1:0] fault_pc_reg, fault_pc_next;
    logic [1:0]      count_reg,    count_next;
    logic            rd_ptr_reg,   rd_ptr_next;
    logic            wr_ptr_reg,   wr_ptr_next;

    logic [ILEN-1:0] entry_instr_reg [DEPTH];
    logic [XLEN-1:0] entry_pc_reg    [DEPTH];

    logic fifo_full;
    logic pop;
    logic pc_bad;
    logic fetch_slot;
    logic push;
    logic fault_trip;

    // -------------------------------------------------------------------------
    // Fetch decision
    // -------------------------------------------------------------------------
    assign fifo_full = (count_reg == 2'(DEPTH));
    assign pop       = instr_valid && instr_ready;

    // Any upper bit above the ROM byte range set means the PC is past the end
    // of the ROM; this also catches a PC that has wrapped through the top of
    // the address space long before the wrap could alias into the ROM.
    assign pc_bad = (pc_reg[1:0] != 2'b00) || (|pc_reg[XLEN-1:LOGWORDS+2]);

    // A fetch slot exists when running, not halted, and there is room (a pop
    // in the same cycle frees the slot of a full FIFO).  A redirect overrides
    // everything, so its cycle never counts as a fetch.
    assign fetch_slot = (state_reg == ST_RUN) && !halt && !redirect &&
                        (!fifo_full || pop);
    assign push       = fetch_slot && !pc_bad;
    assign fault_trip = fetch_slot && pc_bad;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        fault_pc_next = fault_pc_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;

        unique case (state_reg)
            ST_BOOT: begin
                // Single idle cycle before the first fetch.
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (push) begin
                    pc_next = pc_reg + XLEN'(4);
                end
                if (fault_trip) begin
                    state_next    = ST_FAULT;
                    fault_pc_next = pc_reg;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase

        // FIFO bookkeeping.  push is already false in a redirect cycle, and the
        // redirect branch below resets the pointers, so a same-cycle pop is
        // still seen by decode but leaves no trace in the FIFO.
        unique case ({push, pop})
            2'b10: begin
                count_next  = count_reg + 2'd1;
                wr_ptr_next = ~wr_ptr_reg;
            end
            2'b01: begin
                count_next  = count_reg - 2'd1;
                rd_ptr_next = ~rd_ptr_reg;
            end
            2'b11: begin
                wr_ptr_next = ~wr_ptr_reg;
                rd_ptr_next = ~rd_ptr_reg;
            end
            default: begin
            end
        endcase

        // Redirect wins over everything.  In BOOT it simply preloads the PC;
        // BOOT moves to RUN on this edge regardless, so the idle cycle is kept.
        if (redirect) begin
            pc_next     = redirect_pc;
            state_next  = ST_RUN;
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            fault_pc_reg <= '0;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            fault_pc_reg <= fault_pc_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage: one register pair per entry, written when the write
    // pointer selects it.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_instr_reg[gi] <= '0;
                    entry_pc_reg[gi]    <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_instr_reg[gi] <= imem_data;
                    entry_pc_reg[gi]    <= pc_reg;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_addr   = pc_reg;
    assign instr_valid = (count_reg != 2'd0);
    assign instr       = instr_valid ? entry_instr_reg[rd_ptr_reg] : '0;
    assign instr_pc    = instr_valid ? entry_pc_reg[rd_ptr_reg]    : '0;
    assign fault       = (state_reg == ST_FAULT);
    assign fault_pc    = fault_pc_reg;

endmodule
